// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer driving one external 1-bit full adder.
// Operands are shifted LSB-first, the carry lives in a register, and sum bits are collected into result.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             c;
  logic [CNT_W-1:0] cnt;

  // Adder operands come straight from the shift registers; busy mirrors state==RUN.
  assign fa_a   = busy & a_sh[0];
  assign fa_b   = busy & b_sh[0];
  assign fa_cin = busy & c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      c         <= 1'b0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            a_sh  <= op_a;
            b_sh  <= sub ? ~op_b : op_b;
            c     <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          result <= {fa_sum, result[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          c      <= fa_cout;
          if (cnt == LAST_BIT) begin
            // MSB step: carry in vs carry out of the top bit gives signed overflow.
            carry_out <= fa_cout;
            overflow  <= fa_cin ^ fa_cout;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: arithmetic reference model checked every cycle, plus literal
// expectations for the named cases.
module tb_serial_add_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;
  logic         busy, done, carry_out, overflow;
  logic [W-1:0] result;

  serial_add_ctrl #(.WIDTH(W), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out), .overflow(overflow)
  );

  // The shared full adder cell.
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: {overflow, carry, result} from integer arithmetic on the operands.
  function automatic logic [W+1:0] model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
    int          sa, sb, sr;
    int unsigned bb, sum;
    logic        co, ov;
    bb  = s ? ((~int'(b)) & 32'hF) : int'(b);
    sum = int'(a) + bb + int'(s);
    co  = ((sum >> W) & 1) != 0;
    sa  = (int'(a) >= 8) ? int'(a) - 16 : int'(a);
    sb  = (int'(b) >= 8) ? int'(b) - 16 : int'(b);
    sr  = s ? sa - sb : sa + sb;
    ov  = (sr > 7) || (sr < -8);
    return {ov, co, 4'(sum)};
  endfunction

  // Cycle-level expectation: W busy cycles after an accepted start, then one done cycle.
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_res = '0;
  logic         m_co = 1'b0;
  logic         m_ov = 1'b0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic         m_s = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_co   <= 1'b0;
      m_ov   <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0 && !m_done) begin
        if (start) begin
          m_left <= W;
          m_a    <= op_a;
          m_b    <= op_b;
          m_s    <= sub;
        end
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          {m_ov, m_co, m_res} <= model_op(m_a, m_b, m_s);
        end
      end
    end
  end

  // Literal expectations for the named cases, armed by the stimulus block.
  logic         lit_on = 1'b0;
  logic [W-1:0] lit_res = '0;
  logic         lit_co = 1'b0;
  logic         lit_ov = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int          j, mask;
    int unsigned bb, cin;
    check("busy", int'(busy), int'(m_left > 0));
    check("done", int'(done), int'(m_done));
    if (m_left > 0) begin
      j    = W - m_left;
      mask = (1 << j) - 1;
      bb   = m_s ? ((~int'(m_b)) & 32'hF) : int'(m_b);
      cin  = (((int'(m_a) & mask) + (bb & mask) + int'(m_s)) >> j) & 1;
      check("fa_a", int'(fa_a), int'(m_a[j]));
      check("fa_b", int'(fa_b), int'((bb >> j) & 1));
      check("fa_cin", int'(fa_cin), int'(cin));
    end else begin
      check("fa_idle", int'({fa_a, fa_b, fa_cin}), 0);
      check("result", int'(result), int'(m_res));
      check("carry_out", int'(carry_out), int'(m_co));
      check("overflow", int'(overflow), int'(m_ov));
    end
    if (m_done && lit_on) begin
      check("lit_result", int'(result), int'(lit_res));
      check("lit_carry", int'(carry_out), int'(lit_co));
      check("lit_ovf", int'(overflow), int'(lit_ov));
      check("model_vs_lit", int'({m_ov, m_co, m_res}), int'({lit_ov, lit_co, lit_res}));
    end
  end

  // Waits for idle, presents operands with start high, returns once the start was accepted.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    #1;
    op_a  = a;
    op_b  = b;
    sub   = s;
    start = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!busy && n < 40);
  endtask

  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [W-1:0] r, input logic co, input logic ov);
    lit_res = r;
    lit_co  = co;
    lit_ov  = ov;
    lit_on  = 1'b1;
    issue(a, b, s);
    start = 1'b0;
    repeat (W + 2) @(posedge clk);
    #2 lit_on = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    directed(4'd5,  4'd3, 1'b0, 4'b1000, 1'b0, 1'b1);
    directed(4'd15, 4'd1, 1'b0, 4'b0000, 1'b1, 1'b0);
    directed(4'd3,  4'd5, 1'b1, 4'b1110, 1'b0, 1'b0);
    directed(4'd8,  4'd1, 1'b1, 4'b0111, 1'b1, 1'b1);

    // A second start two cycles into RUN, with new operands, must be ignored.
    lit_res = 4'b0111;
    lit_co  = 1'b0;
    lit_ov  = 1'b0;
    lit_on  = 1'b1;
    issue(4'd6, 4'd1, 1'b0);
    start = 1'b0;
    @(posedge clk);
    #2;
    op_a  = 4'd9;
    op_b  = 4'd9;
    sub   = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #2 start = 1'b0;
    repeat (W + 2) @(posedge clk);
    #2 lit_on = 1'b0;

    // Reset in the middle of RUN aborts without a done pulse.
    issue(4'd5, 4'd6, 1'b0);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    directed(4'd7, 4'd2, 1'b0, 4'b1001, 1'b0, 1'b1);

    // Every operand pair in both modes, starts held high for back-to-back operation.
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          issue(4'(a), 4'(b), 1'(s));
        end
      end
    end
    start = 1'b0;
    repeat (W + 4) @(posedge clk);
    #2;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
